// File: rtl/statelogic.sv
`default_nettype none
// ============================================================================
// Module   : statelogic
// Purpose  : Main control FSM of a byte-wide multicycle processor. It walks
//            through a four-byte fetch, decodes the opcode, runs the execute
//            and writeback states, and flags unsupported opcodes or states
//            with a one-cycle registered pulse.
// Revision : 1.0  initial release
// ============================================================================
module statelogic #(
   parameter logic [5:0] LB    = 6'b100000,
   parameter logic [5:0] SB    = 6'b101000,
   parameter logic [5:0] RTYPE = 6'b000000,
   parameter logic [5:0] BEQ   = 6'b000100,
   parameter logic [5:0] J     = 6'b000010
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   output logic [5:0] state,
   output logic       illegal
);

   // State encodings
   localparam logic [5:0] c_FETCH1  = 6'd0;
   localparam logic [5:0] c_FETCH2  = 6'd1;
   localparam logic [5:0] c_FETCH3  = 6'd2;
   localparam logic [5:0] c_FETCH4  = 6'd3;
   localparam logic [5:0] c_DECODE  = 6'd4;
   localparam logic [5:0] c_MEMADR  = 6'd5;
   localparam logic [5:0] c_LBRD    = 6'd6;
   localparam logic [5:0] c_LBWR    = 6'd7;
   localparam logic [5:0] c_SBWR    = 6'd8;
   localparam logic [5:0] c_RTYPEEX = 6'd9;
   localparam logic [5:0] c_RTYPEWR = 6'd10;
   localparam logic [5:0] c_BEQEX   = 6'd11;
   localparam logic [5:0] c_JEX     = 6'd12;

   logic [5:0] r_state;
   logic       r_illegal;
   logic [5:0] w_next;
   logic       w_illegal_next;

   assign state   = r_state;
   assign illegal = r_illegal;

   // State register and illegal flag; reset overrides every transition
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= c_FETCH1;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_illegal <= w_illegal_next;
      end
   end

   // Next-state selection; op only matters in DECODE and MEMADR
   always_comb begin
      w_next = c_FETCH1;
      case (r_state)
         c_FETCH1:  w_next = c_FETCH2;
         c_FETCH2:  w_next = c_FETCH3;
         c_FETCH3:  w_next = c_FETCH4;
         c_FETCH4:  w_next = c_DECODE;
         c_DECODE: begin
            if ((op == LB) || (op == SB)) w_next = c_MEMADR;
            else if (op == RTYPE)         w_next = c_RTYPEEX;
            else if (op == BEQ)           w_next = c_BEQEX;
            else if (op == J)             w_next = c_JEX;
            else                          w_next = c_FETCH1;
         end
         c_MEMADR: begin
            if (op == LB)      w_next = c_LBRD;
            else if (op == SB) w_next = c_SBWR;
            else               w_next = c_FETCH1;
         end
         c_LBRD:    w_next = c_LBWR;
         c_LBWR:    w_next = c_FETCH1;
         c_SBWR:    w_next = c_FETCH1;
         c_RTYPEEX: w_next = c_RTYPEWR;
         c_RTYPEWR: w_next = c_FETCH1;
         c_BEQEX:   w_next = c_FETCH1;
         c_JEX:     w_next = c_FETCH1;
         default:   w_next = c_FETCH1;   // encodings 13..63 recover to fetch
      endcase
   end

   // Fault detection: undefined op in DECODE/MEMADR or an out-of-range state
   always_comb begin
      w_illegal_next = 1'b0;
      case (r_state)
         c_DECODE:
            w_illegal_next = !((op == LB) || (op == SB) || (op == RTYPE) ||
                               (op == BEQ) || (op == J));
         c_MEMADR:
            w_illegal_next = !((op == LB) || (op == SB));
         default:
            w_illegal_next = (r_state > c_JEX);
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_statelogic.sv
`default_nettype none
// ============================================================================
// Module   : tb_statelogic
// Purpose  : Self-checking bench for statelogic. Per-cycle vectors carry the
//            inputs for one edge and the state/illegal expected after it;
//            expectations go through a scoreboard queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_statelogic;

   localparam logic [5:0] c_LB    = 6'b100000;
   localparam logic [5:0] c_SB    = 6'b101000;
   localparam logic [5:0] c_RTYPE = 6'b000000;
   localparam logic [5:0] c_BEQ   = 6'b000100;
   localparam logic [5:0] c_J     = 6'b000010;
   localparam logic [5:0] c_BAD   = 6'b111111;
   localparam logic [5:0] c_BAD2  = 6'b000001;

   typedef struct packed {
      logic       rst;
      logic [5:0] op;
      logic [5:0] st;
      logic       ill;
   } vec_t;

   typedef struct packed {
      logic [5:0] st;
      logic       ill;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [5:0] op;
   logic [5:0] state;
   logic       illegal;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   n_vec;
   int   n_bad;

   statelogic dut (
      .clk     (clk),
      .reset   (reset),
      .op      (op),
      .state   (state),
      .illegal (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add(input logic r, input logic [5:0] o,
                               input logic [5:0] s, input logic i);
      vec_t v;
      v.rst = r; v.op = o; v.st = s; v.ill = i;
      vecs.push_back(v);
   endfunction

   // Normal fetch of four cycles ending in DECODE, with op held at o
   function automatic void add_fetch(input logic [5:0] o);
      add(1'b0, o, 6'd1, 1'b0);
      add(1'b0, o, 6'd2, 1'b0);
      add(1'b0, o, 6'd3, 1'b0);
      add(1'b0, o, 6'd4, 1'b0);
   endfunction

   task automatic check(input string name);
      exp_t e;
      n_vec++;
      if (sb_q.size() == 0) begin
         n_bad++;
         $display("FAIL %s: scoreboard empty, state=%0d illegal=%0b", name, state, illegal);
      end else begin
         e = sb_q.pop_front();
         if (state !== e.st || illegal !== e.ill) begin
            n_bad++;
            $display("FAIL %s: got state=%0d illegal=%0b, expected state=%0d illegal=%0b",
                     name, state, illegal, e.st, e.ill);
         end
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      exp_t e;
      @(negedge clk);
      reset = v.rst;
      op    = v.op;
      e.st  = v.st;
      e.ill = v.ill;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      check(name);
   endtask

   // Plant an out-of-range encoding into the state register, then step one edge
   task automatic force_step(input logic [5:0] bad, input string name);
      exp_t e;
      @(negedge clk);
      reset = 1'b0;
      force dut.r_state = bad;
      #1;
      release dut.r_state;
      e.st  = 6'd0;
      e.ill = 1'b1;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      check(name);
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      reset = 1'b1;
      op    = c_RTYPE;

      // Reset held three cycles, then an R-type instruction
      add(1'b1, c_RTYPE, 6'd0, 1'b0);
      add(1'b1, c_RTYPE, 6'd0, 1'b0);
      add(1'b1, c_RTYPE, 6'd0, 1'b0);
      add_fetch(c_RTYPE);
      add(1'b0, c_RTYPE, 6'd9,  1'b0);
      add(1'b0, c_RTYPE, 6'd10, 1'b0);
      add(1'b0, c_RTYPE, 6'd0,  1'b0);
      // Load byte
      add_fetch(c_LB);
      add(1'b0, c_LB, 6'd5, 1'b0);
      add(1'b0, c_LB, 6'd6, 1'b0);
      add(1'b0, c_LB, 6'd7, 1'b0);
      add(1'b0, c_LB, 6'd0, 1'b0);
      // Store byte
      add_fetch(c_SB);
      add(1'b0, c_SB, 6'd5, 1'b0);
      add(1'b0, c_SB, 6'd8, 1'b0);
      add(1'b0, c_SB, 6'd0, 1'b0);
      // Branch
      add_fetch(c_BEQ);
      add(1'b0, c_BEQ, 6'd11, 1'b0);
      add(1'b0, c_BEQ, 6'd0,  1'b0);
      // Jump, with junk op during fetch to show op is ignored there
      add_fetch(c_BAD);
      add(1'b0, c_J, 6'd12, 1'b0);
      add(1'b0, c_J, 6'd0,  1'b0);
      // Undefined op at DECODE: one-cycle pulse
      add_fetch(c_BAD);
      add(1'b0, c_BAD, 6'd0, 1'b1);
      add(1'b0, c_BAD, 6'd1, 1'b0);
      add(1'b0, c_BAD, 6'd2, 1'b0);
      add(1'b0, c_BAD, 6'd3, 1'b0);
      add(1'b0, c_BAD, 6'd4, 1'b0);
      // op changed to an undefined value while in MEMADR
      add(1'b0, c_LB,   6'd5, 1'b0);
      add(1'b0, c_BAD2, 6'd0, 1'b1);
      add(1'b0, c_LB,   6'd1, 1'b0);
      add(1'b0, c_LB,   6'd2, 1'b0);
      add(1'b0, c_LB,   6'd3, 1'b0);
      add(1'b0, c_LB,   6'd4, 1'b0);
      // Reset in LBRD wins, no pulse
      add(1'b0, c_LB, 6'd5, 1'b0);
      add(1'b0, c_LB, 6'd6, 1'b0);
      add(1'b1, c_LB, 6'd0, 1'b0);
      add(1'b0, c_LB, 6'd1, 1'b0);
      // Reset in a fault cycle suppresses the pulse
      add(1'b0, c_LB,  6'd2, 1'b0);
      add(1'b0, c_LB,  6'd3, 1'b0);
      add(1'b0, c_LB,  6'd4, 1'b0);
      add(1'b1, c_BAD, 6'd0, 1'b0);

      foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

      // Out-of-range states: single fault, then back-to-back faults
      force_step(6'd20, "oor20");
      apply(vec_t'{1'b0, c_J, 6'd1, 1'b0}, "oor20_after");
      force_step(6'd13, "oor13");
      force_step(6'd63, "oor63_b2b");
      apply(vec_t'{1'b0, c_J, 6'd1, 1'b0}, "oor_after");

      // Reset with an out-of-range state gives no pulse
      @(negedge clk);
      force dut.r_state = 6'd40;
      #1;
      release dut.r_state;
      apply(vec_t'{1'b1, c_J, 6'd0, 1'b0}, "oor_reset");

      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
